// File: rtl/reduce_unit_pkg.sv
// Shared definitions for the reduce_unit slice: op and state encodings and the
// accumulator identity helper.
package reduce_defs;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // AND starts from 1; OR, XOR and NOR start from 0.
  function automatic logic identity(op_t op);
    return (op == OP_AND);
  endfunction

endpackage

// File: rtl/reduce_unit_if.sv
// Start/busy/done handshake and operand bus between the control unit (master)
// and reduce_unit (slave).
interface reduce_unit_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic             result;

  modport master (output start, op, data_in, input ready, busy, done, result);
  modport slave  (input start, op, data_in, output ready, busy, done, result);
endinterface

// File: rtl/reduce_unit_chunk.sv
// Combinational CHUNK-bit reducer; NOR reduces as OR, the inversion is applied
// once on the final result in reduce_unit.
module reduce_chunk
  import reduce_defs::*;
#(
  parameter int CHUNK = 8
) (
  input  op_t              op,
  input  logic [CHUNK-1:0] chunk,
  output logic             red
);

  always_comb begin
    red = 1'b0;
    case (op)
      OP_AND:  red = &chunk;
      OP_XOR:  red = ^chunk;
      default: red = |chunk;
    endcase
  end

endmodule

// File: rtl/reduce_unit.sv
// Multi-cycle WIDTH-bit reduction (OR/AND/XOR/NOR), CHUNK bits per clock.
// Optional REDUCE_UNIT_EARLY_EXIT_EN: leave RUN once the accumulator saturates.
//
// state   | meaning
// IDLE    | waiting for start, ready=1
// RUN     | folding one chunk per edge, busy=1
// DONE    | one-cycle done pulse, ready=1, back-to-back start accepted
module reduce_unit
  import reduce_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic          clk,
  input logic          reset,
  reduce_unit_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  op_t              op_q;
  logic             acc;
  logic [CW-1:0]    cnt;
  logic             busy_q, done_q, ready_q, result_q;
  logic             chunk_red, acc_next, finish;

  // The operand shifts right each pass, so the low chunk is always chunk i.
  reduce_chunk #(.CHUNK(CHUNK)) u_chunk (
    .op    (op_q),
    .chunk (sreg[CHUNK-1:0]),
    .red   (chunk_red)
  );

  always_comb begin
    acc_next = acc;
    case (op_q)
      OP_AND:  acc_next = acc & chunk_red;
      OP_XOR:  acc_next = acc ^ chunk_red;
      default: acc_next = acc | chunk_red;
    endcase
  end

`ifdef REDUCE_UNIT_EARLY_EXIT_EN
  logic sat;
  always_comb begin
    sat = 1'b0;
    case (op_q)
      OP_AND:  sat = ~acc_next;
      OP_XOR:  sat = 1'b0;
      default: sat = acc_next;
    endcase
  end
  assign finish = (cnt == LAST) || sat;
`else
  assign finish = (cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      op_q     <= OP_OR;
      acc      <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      result_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            sreg    <= bus.data_in;
            op_q    <= op_t'(bus.op);
            acc     <= identity(op_t'(bus.op));
            cnt     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            state   <= ST_RUN;
          end else begin
            done_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc  <= acc_next;
          sreg <= sreg >> CHUNK;
          if (finish) begin
            result_q <= (op_q == OP_NOR) ? ~acc_next : acc_next;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_reduce_unit.sv
// Self-checking bench for reduce_unit (WIDTH=32, CHUNK=8): vector table,
// randomized operands against a reference model, and handshake/reset corners.
module tb_reduce_unit;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reduce_unit_if #(.WIDTH(WIDTH)) bus ();

  reduce_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic        res;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: reduction defined on the whole operand.
  function automatic logic model_res(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'b00:   return d != 32'h0;
      2'b01:   return d == 32'hFFFF_FFFF;
      2'b10:   return ($countones(d) % 2) == 1;
      default: return d == 32'h0;
    endcase
  endfunction

  // Number of RUN edges before done: N, or the first saturating chunk with early exit.
  function automatic int model_lat(input logic [1:0] op, input logic [31:0] d);
`ifdef REDUCE_UNIT_EARLY_EXIT_EN
    for (int k = 0; k < N; k++) begin
      logic [CHUNK-1:0] c;
      c = d[k*CHUNK +: CHUNK];
      if ((op == 2'b00 || op == 2'b11) && c != '0) return k + 1;
      if (op == 2'b01 && c != '1) return k + 1;
    end
`endif
    return N;
  endfunction

  // Counts edges after E0 until done is seen; lat=0 on timeout.
  task automatic wait_done(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= N + 2 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        lat  = k;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic exp_res,
                        input string name);
    int lat;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op      = 2'($urandom);
    bus.data_in = $urandom;
    check({name, " busy after accept"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({name, " latency"}, 32'(lat), 32'(model_lat(op, d)));
    check({name, " result"}, 32'(bus.result), 32'(exp_res));
    check({name, " ready in done cycle"}, 32'(bus.ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({name, " done single cycle"}, 32'(bus.done), 32'd0);
    check({name, " result held"}, 32'(bus.result), 32'(exp_res));
  endtask

  vec_t tbl[8];

  initial begin
    int lat;
    bit stray;

    tbl[0] = '{2'b00, 32'h0000_0100, 1'b1, "or_0100"};
    tbl[1] = '{2'b11, 32'h0000_0000, 1'b1, "nor_zero"};
    tbl[2] = '{2'b11, 32'h8000_0000, 1'b0, "nor_msb"};
    tbl[3] = '{2'b01, 32'hFFFF_FFFF, 1'b1, "and_ones"};
    tbl[4] = '{2'b01, 32'hFFFF_FFFE, 1'b0, "and_lsb0"};
    tbl[5] = '{2'b10, 32'h0000_0007, 1'b1, "xor_7"};
    tbl[6] = '{2'b10, 32'h0000_0003, 1'b0, "xor_3"};
    tbl[7] = '{2'b00, 32'h0000_0001, 1'b1, "or_0001"};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i].op, tbl[i].data, tbl[i].res, tbl[i].name);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       d = $urandom;
        1:       d = 32'h0;
        2:       d = 32'hFFFF_FFFF;
        3:       d = 32'h1 << $urandom_range(0, 31);
        default: d = ~(32'h1 << $urandom_range(0, 31));
      endcase
      run_op(op, d, model_res(op, d), $sformatf("rand%0d", i));
    end

    // Start held high, inputs change during RUN; done-cycle start is accepted.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.op      = 2'b01;
    bus.data_in = 32'hFFFF_FFFF;
    wait_done(lat);
    check("held latency", 32'(lat), 32'(N));
    check("held result", 32'(bus.result), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b done fell", 32'(bus.done), 32'd0);
    check("b2b busy", 32'(bus.busy), 32'd1);
    check("b2b ready", 32'(bus.ready), 32'd0);
    bus.start = 1'b0;
    wait_done(lat);
    check("b2b latency", 32'(lat), 32'(model_lat(2'b01, 32'hFFFF_FFFF)));
    check("b2b result", 32'(bus.result), 32'd1);
    @(posedge clk);
    @(negedge clk);

    // Reset at E2 of an OR run discards it.
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrun reset busy", 32'(bus.busy), 32'd0);
    check("midrun reset done", 32'(bus.done), 32'd0);
    check("midrun reset result", 32'(bus.result), 32'd0);
    check("midrun reset ready", 32'(bus.ready), 32'd1);
    stray = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) stray = 1;
    end
    check("no done after reset", 32'(stray), 32'd0);

    // Reset and start on the same edge: reset wins.
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    bus.data_in = 32'hFFFF_FFFF;
    reset       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("reset+start busy", 32'(bus.busy), 32'd0);
    check("reset+start ready", 32'(bus.ready), 32'd1);
    stray = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) stray = 1;
    end
    check("reset+start no run", 32'(stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
